spi_reg_bank: RTL

//  SPI (mode 0) register-bank peripheral: parametrised register count and data width, with write and read-back.

---
 rtl/spi_reg_bank_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_bank.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: frame geometry, rw encoding,
// error counter width and the commit decision type.
package spi_reg_bank_pkg;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;
    localparam int   ERR_W    = 8;

    // Outcome of a frame when chip select is released
    typedef enum logic [1:0] {
        CMT_NONE,
        CMT_WRITE,
        CMT_READ,
        CMT_ERROR
    } commit_e;

    // Frame is [rw][addr][data], MSB first
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous SPI pin: SYNC_STAGES flop chain followed
// by a delayed copy so rise/fall are single-clk pulses in the clk domain.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_d;

    // Shift the pin through the chain; q_d keeps last cycle's synced value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            q_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: writable registers with per-register commit
// strobes, CIPO read-back and a saturating count of rejected frames.
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_sclk,
    input  logic                         spi_copi,
    input  logic                         spi_cs,
    output logic                         spi_cipo,
    output logic                         spi_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic [ERR_W-1:0]             err_count
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_W + 1);
    // Count value seen on the rise that completes the rw+addr header
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W);

    // ---------------------------------------------------------------
    // Pin synchronisers: [2]=select (inverted cs), [1]=copi, [0]=sclk.
    // cs is inverted so every chain can reset to 0 while still reading
    // as "deselected" out of reset.
    // ---------------------------------------------------------------
    logic [2:0] pin_q, pin_rise, pin_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync [2:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({~spi_cs, spi_copi, spi_sclk}),
        .q     (pin_q),
        .rise  (pin_rise),
        .fall  (pin_fall)
    );

    logic sel, copi, sclk_rise, sclk_fall, cs_rise;
    assign sel       = pin_q[2];
    assign copi      = pin_q[1];
    assign sclk_rise = pin_rise[0];
    assign sclk_fall = pin_fall[0];
    assign cs_rise   = pin_fall[2];

    logic unused_sync;
    assign unused_sync = ^{pin_rise[2:1], pin_fall[1], pin_q[0]};

    // ---------------------------------------------------------------
    // Register storage
    // ---------------------------------------------------------------
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    assign regs_out = regs;

    // ---------------------------------------------------------------
    // Shift / count
    // ---------------------------------------------------------------
    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] shreg;

    // Shift copi in on each sclk rise while selected; count saturates at the overflow marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (!sel) begin
            cnt   <= '0;
        end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_W-2:0], copi};
            if (cnt != CNT_OVF)
                cnt <= cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Read path: header as it will look after the current rise
    // ---------------------------------------------------------------
    logic [ADDR_W:0]   hdr_next;
    logic              hdr_rw;
    logic [ADDR_W-1:0] hdr_addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] shadow;

    assign hdr_next = {shreg[ADDR_W-1:0], copi};
    assign hdr_rw   = hdr_next[ADDR_W];
    assign hdr_addr = hdr_next[ADDR_W-1:0];

    // Register lookup for read-back; out-of-range addresses read as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (hdr_addr == ADDR_W'(i))
                rd_word = regs[i];
    end

    // Load tx shadow at end of header, then shift it out MSB first on sclk falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            spi_cipo <= 1'b0;
        end else if (!sel) begin
            shadow   <= '0;
            spi_cipo <= 1'b0;
        end else if (sclk_rise && cnt == CNT_HDR) begin
            shadow   <= (hdr_rw == RW_READ) ? rd_word : '0;
        end else if (sclk_fall) begin
            spi_cipo <= shadow[DATA_W-1];
            shadow   <= shadow << 1;
        end
    end

    assign spi_cipo_oe = sel;

    // ---------------------------------------------------------------
    // Commit decode on cs release
    // ---------------------------------------------------------------
    logic              fr_rw;
    logic [ADDR_W-1:0] fr_addr;
    logic [DATA_W-1:0] fr_data;
    logic              addr_ok;
    commit_e           cmt;

    assign fr_rw   = shreg[FRAME_W-1];
    assign fr_addr = shreg[FRAME_W-2 -: ADDR_W];
    assign fr_data = shreg[DATA_W-1:0];
    assign addr_ok = ({1'b0, fr_addr} < (ADDR_W+1)'(NUM_REGS));

    // Classify the finished frame; a cs pulse with no clocks is not an error
    always_comb begin
        cmt = CMT_NONE;
        if (cs_rise && cnt != '0) begin
            if (cnt != CNT_FULL)
                cmt = CMT_ERROR;
            else if (fr_rw == RW_READ)
                cmt = CMT_READ;
            else if (fr_rw == RW_WRITE && addr_ok)
                cmt = CMT_WRITE;
            else
                cmt = CMT_ERROR;
        end
    end

    // Apply the commit: register write plus one-clk strobe, or error count bump
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs      <= '0;
            wr_strobe <= '0;
            err_count <= '0;
        end else begin
            wr_strobe <= '0;
            case (cmt)
                CMT_WRITE: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (fr_addr == ADDR_W'(i)) begin
                            regs[i]      <= fr_data;
                            wr_strobe[i] <= 1'b1;
                        end
                    end
                end
                CMT_ERROR: begin
                    if (err_count != '1)
                        err_count <= err_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
